seq_match_arbiter: RTL and testbench
====================================

Name: seq_match_arbiter

Overview:
- Time-shares one serial pattern-match engine among NREQ requesters.
- Each requester presents a WORD_W-bit word. The block grants one requester, serialises its word MSB-first through the engine and returns the number of occurrences of a programmable PAT_W-bit pattern.
- Sits in front of the fsm-style sequence detectors. It is the scheduler that feeds them and collects their results.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WORD_W, 8, bits per request word.
- PAT_W, 4, pattern length; 1 <= PAT_W <= WORD_W.
- IDW, $clog2(NREQ), width of the requester ID (derived).
- CNTW, $clog2(WORD_W+1), width of the match count (derived).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- CFG_PATTERN  in  PAT_W  pattern to detect; sampled at grant.
- REQ_VALID  in  NREQ  per-requester request.
- REQ_DATA  in  NREQ*WORD_W  per-requester word; slice i is [i*WORD_W +: WORD_W].
- REQ_READY  out  NREQ  one-hot grant/accept pulse.
- RSP_VALID  out  1  result strobe, 1 cycle.
- RSP_ID  out  IDW  requester the result belongs to.
- RSP_COUNT  out  CNTW  number of pattern occurrences in the word.
- RSP_MATCH  out  1  RSP_COUNT != 0.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE.
  - REQ_READY, RSP_VALID, RSP_ID, RSP_COUNT, RSP_MATCH and BUSY = 0.
  - RR pointer last_id = NREQ-1, so requester 0 wins first.
  - Shift, history and bit counters = 0.
  - A reset mid-word drops that word; no response is issued for it.
- FSM states: IDLE, GRANT, SHIFT, REPORT.
- IDLE:
  - If REQ_VALID != 0, pick winner w = first set bit searching from last_id+1 upward, wrapping.
  - Next state = GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle):
  - REQ_READY[w] = 1 (registered, one-hot). The handshake completes this cycle.
  - Capture REQ_DATA[w] into the shift register and CFG_PATTERN into the pattern register.
  - Clear the history register and counters. Set last_id = w. Next state = SHIFT.
  - If REQ_VALID[w] dropped before this cycle, the word is still taken. Requesters must hold VALID/DATA stable until READY.
- SHIFT (exactly WORD_W cycles):
  - Each cycle, shift the MSB of the word into the LSB of the PAT_W-bit history.
  - Increment bits_seen.
  - After the shift, if bits_seen >= PAT_W and history == pattern, increment the count.
  - Overlapping matches are counted.
  - History does not carry over between words.
  - After the WORD_W-th bit, next state = REPORT.
- REPORT (1 cycle):
  - RSP_VALID = 1, with RSP_ID = w, RSP_COUNT and RSP_MATCH.
  - No backpressure; the response is lost if unobserved. Next state = IDLE.
- Latency: RSP_VALID rises WORD_W+1 cycles after the REQ_READY cycle. Throughput is 1 word per WORD_W+3 cycles.
- Count range: maximum is WORD_W-PAT_W+1, so there is no saturation logic.
- CFG_PATTERN changes outside GRANT do not affect a word in flight.
- REQ_VALID changes during SHIFT/REPORT are ignored until the next IDLE.

Optional Feature:
- Macro: SEQ_MATCH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index always wins; last_id is unused and may be removed.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package seq_match_pkg holds:
  - the state enum (IDLE/GRANT/SHIFT/REPORT);
  - the default NREQ/WORD_W/PAT_W constants;
  - a function computing CNTW.
- One natural sub-module: seq_match_engine. It contains the shift register, history, bits_seen and counter, with inputs load/data/pattern/step and outputs count/done.
- The arbiter and FSM stay in the top module.

Test Plan:
- Reset and single match: hold RST=0 mid-SHIFT → all outputs 0 asynchronously and no RSP_VALID afterwards. Then release, with CFG_PATTERN=4'b0111, REQ_VALID=4'b0001, REQ_DATA[0]=8'b0111_0001 → REQ_READY=4'b0001, then 9 cycles later RSP_VALID with ID=0, COUNT=1, MATCH=1.
- Two matches: CFG_PATTERN=4'b0111, word 8'b0111_0111 on requester 2 → ID=2, COUNT=2.
- Overlapping matches: CFG_PATTERN=4'b1010, word 8'b1010_1010 → COUNT=3.
- No match: CFG_PATTERN=4'b0111, word 8'hFF → COUNT=0, MATCH=0.
- Round-robin: REQ_VALID=4'b1111 held continuously → grant order 0,1,2,3,0, responses spaced WORD_W+3=11 cycles apart. With SEQ_MATCH_ARB_FIXED_PRIO_EN defined → grants 0,0,0,0,0.
- Config isolation: change CFG_PATTERN from 4'b0111 to 4'b0000 during SHIFT of word 8'b0111_0001 → COUNT=1. The next word uses 4'b0000.

Source files
------------

// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared definitions for the sequence-match arbiter slice.
//   - state_e  : arbiter FSM states (IDLE/GRANT/SHIFT/REPORT)
//   - DEF_*    : default NREQ / WORD_W / PAT_W
//   - cntw_f() : width needed to hold a match count of 0..word_w
package seq_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 4;

  // A word of word_w bits can hold at most word_w matches (PAT_W = 1),
  // so the counter must represent 0..word_w inclusive.
  function automatic int cntw_f(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_engine.sv
// seq_match_engine: serial pattern counter shared by all requesters.
// Ports:
//   clk_i, rst_ni  clock / asynchronous active-low reset
//   load_i         capture data_i and pattern_i, clear history and counters
//   step_i         shift one word bit (MSB first) into the history
//   data_i         WORD_W-bit word to scan
//   pattern_i      PAT_W-bit pattern to look for
//   count_o        match count including the current step (if step_i)
//   done_o         high on the step that consumes the last word bit
module seq_match_engine
  import seq_match_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNTW   = cntw_f(DEF_WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [PAT_W-1:0]  pattern_i,
  output logic [CNTW-1:0]   count_o,
  output logic              done_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNTW-1:0]   bits_q, bits_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic [PAT_W-1:0]  hist_step;
  logic [CNTW-1:0]   bits_step;
  logic [CNTW-1:0]   count_step;
  logic              hit;

  // Result of shifting one bit this cycle; the history only counts as a
  // candidate once PAT_W real bits have entered it.
  always_comb begin
    hist_step  = PAT_W'({hist_q, shreg_q[WORD_W-1]});
    bits_step  = bits_q + CNTW'(1);
    hit        = (bits_step >= CNTW'(PAT_W)) && (hist_step == pat_q);
    count_step = count_q + CNTW'(hit);
  end

  // Next-state selection: load has priority, otherwise step or hold.
  always_comb begin
    shreg_d = shreg_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    bits_d  = bits_q;
    count_d = count_q;
    if (load_i) begin
      shreg_d = data_i;
      pat_d   = pattern_i;
      hist_d  = '0;
      bits_d  = '0;
      count_d = '0;
    end else if (step_i) begin
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      hist_d  = hist_step;
      bits_d  = bits_step;
      count_d = count_step;
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      hist_q  <= '0;
      pat_q   <= '0;
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

  // count_o looks through the current step so the caller can register the
  // final count on the same edge that consumes the last bit.
  always_comb begin
    if (step_i) begin
      count_o = count_step;
    end else begin
      count_o = count_q;
    end
    done_o = step_i && (bits_q == CNTW'(WORD_W - 1));
  end

endmodule

// File: rtl/seq_match_arbiter.sv
// seq_match_arbiter: grants one of NREQ requesters, runs its word through
// the shared seq_match_engine and reports the pattern-occurrence count.
// Ports:
//   CLK, RST      clock / asynchronous active-low reset
//   CFG_PATTERN   pattern, sampled in the GRANT cycle
//   REQ_VALID     per-requester request
//   REQ_DATA      per-requester word, slice i = [i*WORD_W +: WORD_W]
//   REQ_READY     registered one-hot grant pulse (GRANT cycle)
//   RSP_VALID     one-cycle result strobe with RSP_ID/RSP_COUNT/RSP_MATCH
//   BUSY          high in every state except IDLE
// Build option: SEQ_MATCH_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins); otherwise round-robin starting after the last winner.
module seq_match_arbiter
  import seq_match_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  localparam int IDW   = $clog2(NREQ),
  localparam int CNTW  = cntw_f(WORD_W)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [PAT_W-1:0]       CFG_PATTERN,
  input  logic [NREQ-1:0]        REQ_VALID,
  input  logic [NREQ*WORD_W-1:0] REQ_DATA,
  output logic [NREQ-1:0]        REQ_READY,
  output logic                   RSP_VALID,
  output logic [IDW-1:0]         RSP_ID,
  output logic [CNTW-1:0]        RSP_COUNT,
  output logic                   RSP_MATCH,
  output logic                   BUSY
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [CNTW-1:0]   rsp_count_q, rsp_count_d;
  logic              rsp_match_q, rsp_match_d;
  logic              busy_q, busy_d;
`ifndef SEQ_MATCH_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]    last_id_q, last_id_d;
`endif

  logic [IDW-1:0]    pick;
  logic [WORD_W-1:0] grant_data;
  logic              eng_load;
  logic              eng_step;
  logic [CNTW-1:0]   eng_count;
  logic              eng_done;

`ifdef SEQ_MATCH_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest set index is written last.
  always_comb begin
    pick = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (REQ_VALID[j]) begin
        pick = IDW'(j);
      end else begin
        pick = pick;
      end
    end
  end
`else
  // Round-robin: scan offsets from farthest to nearest after last_id so the
  // first requester at or after last_id+1 (wrapping) is written last.
  always_comb begin
    pick = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (REQ_VALID[(int'(last_id_q) + off) % NREQ]) begin
        pick = IDW'((int'(last_id_q) + off) % NREQ);
      end else begin
        pick = pick;
      end
    end
  end
`endif

  // Select the granted requester's word for loading into the engine.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IDW'(i)) begin
        grant_data = REQ_DATA[i*WORD_W +: WORD_W];
      end else begin
        grant_data = grant_data;
      end
    end
  end

  seq_match_engine #(
    .WORD_W (WORD_W),
    .PAT_W  (PAT_W),
    .CNTW   (CNTW)
  ) u_engine (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .load_i    (eng_load),
    .step_i    (eng_step),
    .data_i    (grant_data),
    .pattern_i (CFG_PATTERN),
    .count_o   (eng_count),
    .done_o    (eng_done)
  );

  // FSM next state; grant and response registers are loaded on the edge
  // entering GRANT / REPORT so they appear exactly during those states.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ready_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_count_d = '0;
    rsp_match_d = 1'b0;
    eng_load    = 1'b0;
    eng_step    = 1'b0;
`ifndef SEQ_MATCH_ARB_FIXED_PRIO_EN
    last_id_d   = last_id_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID != '0) begin
          win_d   = pick;
          ready_d = NREQ'(1) << pick;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        eng_load  = 1'b1;
`ifndef SEQ_MATCH_ARB_FIXED_PRIO_EN
        last_id_d = win_q;
`endif
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        eng_step = 1'b1;
        if (eng_done) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = win_q;
          rsp_count_d = eng_count;
          rsp_match_d = (eng_count != '0);
          state_d     = ST_REPORT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_match_q <= 1'b0;
      busy_q      <= 1'b0;
`ifndef SEQ_MATCH_ARB_FIXED_PRIO_EN
      last_id_q   <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_match_q <= rsp_match_d;
      busy_q      <= busy_d;
`ifndef SEQ_MATCH_ARB_FIXED_PRIO_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_COUNT = rsp_count_q;
  assign RSP_MATCH = rsp_match_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_seq_match_arbiter.sv
// tb_seq_match_arbiter: self-checking bench for seq_match_arbiter with a
// behavioural model (arbitration rule + sliding-window occurrence count).
module tb_seq_match_arbiter;

  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int IDW    = $clog2(NREQ);
  localparam int CNTW   = $clog2(WORD_W + 1);

  logic                   CLK;
  logic                   RST;
  logic [PAT_W-1:0]       CFG_PATTERN;
  logic [NREQ-1:0]        REQ_VALID;
  logic [NREQ*WORD_W-1:0] REQ_DATA;
  logic [NREQ-1:0]        REQ_READY;
  logic                   RSP_VALID;
  logic [IDW-1:0]         RSP_ID;
  logic [CNTW-1:0]        RSP_COUNT;
  logic                   RSP_MATCH;
  logic                   BUSY;

  int total;
  int bad;
  int last_m;

  seq_match_arbiter dut (
    .CLK         (CLK),
    .RST         (RST),
    .CFG_PATTERN (CFG_PATTERN),
    .REQ_VALID   (REQ_VALID),
    .REQ_DATA    (REQ_DATA),
    .REQ_READY   (REQ_READY),
    .RSP_VALID   (RSP_VALID),
    .RSP_ID      (RSP_ID),
    .RSP_COUNT   (RSP_COUNT),
    .RSP_MATCH   (RSP_MATCH),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Which requester should win given the valid mask and previous winner.
  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
`ifdef SEQ_MATCH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return 0;
  endfunction

  // Occurrences of pat in w, overlapping allowed: slide a PAT_W window.
  function automatic int model_count(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] pat);
    int c;
    logic [WORD_W-1:0] t;
    c = 0;
    for (int p = 0; p <= WORD_W - PAT_W; p++) begin
      t = w >> p;
      if (t[PAT_W-1:0] == pat) c++;
    end
    return c;
  endfunction

  task automatic apply_reset();
    RST = 1'b0;
    REQ_VALID = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    last_m = NREQ - 1;
  endtask

  // One transaction; optionally change CFG_PATTERN chg_at cycles after grant.
  task automatic run_txn(input string name, input logic [NREQ-1:0] vmask,
                         input logic [NREQ*WORD_W-1:0] data, input logic [PAT_W-1:0] pat,
                         input int chg_at, input logic [PAT_W-1:0] chg_pat);
    int exp_id, exp_cnt, lat;
    bit got;
    logic [NREQ-1:0] exp_rdy;
    logic [WORD_W-1:0] w;
    exp_id = model_pick(vmask, last_m);
    w = data[exp_id*WORD_W +: WORD_W];
    exp_cnt = model_count(w, pat);
    exp_rdy = '0;
    exp_rdy[exp_id] = 1'b1;
    @(negedge CLK);
    CFG_PATTERN = pat;
    REQ_DATA = data;
    REQ_VALID = vmask;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (REQ_READY != '0) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s grant_timeout: no REQ_READY within 20 cycles", name);
      REQ_VALID = '0;
      return;
    end
    if (REQ_READY !== exp_rdy || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL %s grant: ready=%b busy=%b required ready=%b busy=1", name, REQ_READY, BUSY, exp_rdy);
    end
    last_m = exp_id;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) REQ_VALID = '0;
      if (lat == chg_at) CFG_PATTERN = chg_pat;
      if (RSP_VALID) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got || lat != WORD_W + 1) begin
      bad++;
      $display("FAIL %s latency: got=%0d seen=%0d required=%0d", name, lat, got, WORD_W + 1);
    end
    total++;
    if (RSP_ID !== IDW'(exp_id) || RSP_COUNT !== CNTW'(exp_cnt) || RSP_MATCH !== (exp_cnt != 0)) begin
      bad++;
      $display("FAIL %s response: id=%0d count=%0d match=%b required id=%0d count=%0d match=%b",
               name, RSP_ID, RSP_COUNT, RSP_MATCH, exp_id, exp_cnt, (exp_cnt != 0));
    end
    @(negedge CLK);
    total++;
    if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL %s after_report: rsp_valid=%b busy=%b required 0 0", name, RSP_VALID, BUSY);
    end
  endtask

  task automatic test_reset();
    bit seen;
    RST = 1'b0;
    REQ_VALID = '0;
    REQ_DATA = '0;
    CFG_PATTERN = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({REQ_READY, RSP_VALID, RSP_ID, RSP_COUNT, RSP_MATCH, BUSY} !== '0) begin
      bad++;
      $display("FAIL reset_state: outputs=%b required all 0", {REQ_READY, RSP_VALID, RSP_ID, RSP_COUNT, RSP_MATCH, BUSY});
    end
    RST = 1'b1;
    @(negedge CLK);
    CFG_PATTERN = 4'b0111;
    REQ_DATA = '0;
    REQ_DATA[7:0] = 8'b0111_0001;
    REQ_VALID = 4'b0001;
    repeat (6) @(negedge CLK);
    REQ_VALID = '0;
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL reset_midshift_busy: busy=%b required 1", BUSY);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({REQ_READY, RSP_VALID, RSP_ID, RSP_COUNT, RSP_MATCH, BUSY} !== '0) begin
      bad++;
      $display("FAIL reset_async: outputs=%b required all 0", {REQ_READY, RSP_VALID, RSP_ID, RSP_COUNT, RSP_MATCH, BUSY});
    end
    @(negedge CLK);
    RST = 1'b1;
    last_m = NREQ - 1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (RSP_VALID) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_drop: rsp_valid seen=1 required 0");
    end
  endtask

  task automatic test_directed();
    logic [NREQ*WORD_W-1:0] d;
    d = {$urandom, $urandom};
    d[0*WORD_W +: WORD_W] = 8'b0111_0001;
    run_txn("single_match", 4'b0001, d, 4'b0111, 0, 4'b0000);
    d[2*WORD_W +: WORD_W] = 8'b0111_0111;
    run_txn("two_matches", 4'b0100, d, 4'b0111, 0, 4'b0000);
    d[1*WORD_W +: WORD_W] = 8'b1010_1010;
    run_txn("overlap", 4'b0010, d, 4'b1010, 0, 4'b0000);
    d[3*WORD_W +: WORD_W] = 8'hFF;
    run_txn("no_match", 4'b1000, d, 4'b0111, 0, 4'b0000);
  endtask

  task automatic test_round_robin();
    int exp_q[$];
    int exp_id, nrsp, prev_t, cyc;
    logic [NREQ*WORD_W-1:0] d;
    logic [NREQ-1:0] exp_rdy;
    logic [PAT_W-1:0] pat;
    apply_reset();
    d = {$urandom, $urandom};
    pat = 4'b0111;
    @(negedge CLK);
    REQ_DATA = d;
    CFG_PATTERN = pat;
    REQ_VALID = '1;
    nrsp = 0;
    prev_t = 0;
    for (cyc = 1; cyc <= 80 && nrsp < 5; cyc++) begin
      @(negedge CLK);
      if (REQ_READY != '0) begin
        exp_id = model_pick('1, last_m);
        exp_rdy = '0;
        exp_rdy[exp_id] = 1'b1;
        total++;
        if (REQ_READY !== exp_rdy) begin
          bad++;
          $display("FAIL rr_grant: ready=%b required=%b", REQ_READY, exp_rdy);
        end
        last_m = exp_id;
        exp_q.push_back(exp_id);
      end
      if (RSP_VALID) begin
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        total++;
        if (exp_id < 0 || RSP_ID !== IDW'(exp_id) ||
            RSP_COUNT !== CNTW'(model_count(d[exp_id*WORD_W +: WORD_W], pat))) begin
          bad++;
          $display("FAIL rr_response: id=%0d count=%0d required id=%0d", RSP_ID, RSP_COUNT, exp_id);
        end
        if (nrsp > 0) begin
          total++;
          if (cyc - prev_t != WORD_W + 3) begin
            bad++;
            $display("FAIL rr_spacing: gap=%0d required=%0d", cyc - prev_t, WORD_W + 3);
          end
        end
        prev_t = cyc;
        nrsp++;
      end
    end
    REQ_VALID = '0;
    total++;
    if (nrsp != 5) begin
      bad++;
      $display("FAIL rr_count: responses=%0d required=5", nrsp);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_config_isolation();
    logic [NREQ*WORD_W-1:0] d;
    d = {$urandom, $urandom};
    d[0*WORD_W +: WORD_W] = 8'b0111_0001;
    run_txn("cfg_inflight", 4'b0001, d, 4'b0111, 3, 4'b0000);
    d[1*WORD_W +: WORD_W] = 8'b0000_0001;
    run_txn("cfg_next_word", 4'b0010, d, 4'b0000, 0, 4'b0000);
  endtask

  task automatic test_random();
    logic [NREQ*WORD_W-1:0] d;
    logic [NREQ-1:0] v;
    logic [PAT_W-1:0] pat;
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      pat = PAT_W'($urandom);
      run_txn("random", v, d, pat, 0, 4'b0000);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_m = NREQ - 1;
    test_reset();
    test_directed();
    test_round_robin();
    test_config_isolation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
